// File: rtl/mips_trace_pkg.sv
// ----------------------------------------------------------------------------
// mips_trace_pkg : shared state encoding and field-width helpers for the trace unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mips_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } trace_state_t;

  // Channel-index width; never narrower than one bit.
  function automatic int chan_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

  // FIFO pointer width; count is one bit wider to represent "full".
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mips_trace_fifo.sv
// ----------------------------------------------------------------------------
// mips_trace_fifo : show-ahead circular FIFO with simultaneous push/pop at any occupancy
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mips_trace_fifo
  import mips_trace_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [ptr_w(DEPTH):0]  count
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs, even when full.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Gate with empty so the outputs read zero after reset without clearing storage.
  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/mips_trace_buffer.sv
// ----------------------------------------------------------------------------
// mips_trace_buffer : change-triggered trace capture with cycle-limited run window.
// Optional macro TRACE_TIMESTAMP_EN builds timestamp storage. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mips_trace_buffer
  import mips_trace_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CH          = 2,
  parameter int DEPTH       = 16,
  parameter int TS_W        = 16,
  parameter int CYCLE_LIMIT = 25
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic [CH-1:0]          obs_valid,
  input  logic [CH*DATA_W-1:0]   obs_data,
  input  logic                   rd_ready,
  output logic                   rd_valid,
  output logic [chan_w(CH)-1:0]  rd_chan,
  output logic [DATA_W-1:0]      rd_data,
  output logic [TS_W-1:0]        rd_ts,
  output logic [ptr_w(DEPTH):0]  count,
  output logic                   overflow,
  output logic                   running
);

  localparam int CHAN_W = chan_w(CH);
  localparam int PTR_W  = ptr_w(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = CHAN_W + DATA_W + TS_W;
`else
  localparam int ENTRY_W = CHAN_W + DATA_W;
`endif
  localparam logic [TS_W-1:0] LIMIT_M1 = TS_W'(CYCLE_LIMIT - 1);

  trace_state_t      state;
  trace_state_t      state_next;
  logic [TS_W-1:0]   cycle_cnt;
  logic              limit_hit;

  logic [DATA_W-1:0] last_seen [CH];
  logic [DATA_W-1:0] pend_val  [CH];
`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0]   pend_ts   [CH];
`endif
  logic [CH-1:0]     seen;
  logic [CH-1:0]     pending;
  logic [CH-1:0]     change;
  logic [CH-1:0]     drain;

  logic [CHAN_W-1:0] sel;
  logic              any_pend;
  logic              pop;
  logic              push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign limit_hit = (CYCLE_LIMIT != 0) && (cycle_cnt == LIMIT_M1);
  assign running   = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, STOPPED: if (arm)       state_next = RUN;
      RUN:           if (limit_hit) state_next = STOPPED;
      default:                      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  cycle_cnt <= '0;
    else if (state != RUN && state_next == RUN) cycle_cnt <= '0;
    else if (state == RUN)                      cycle_cnt <= cycle_cnt + 1'b1;
  end

  always_comb begin
    change = '0;
    for (int i = 0; i < CH; i++) begin
      change[i] = (state == RUN) && obs_valid[i] &&
                  (!seen[i] || (obs_data[i*DATA_W +: DATA_W] != last_seen[i]));
    end
  end

  // Fixed priority: scanning downward leaves the lowest pending index selected.
  always_comb begin
    sel      = '0;
    any_pend = 1'b0;
    for (int i = CH - 1; i >= 0; i--) begin
      if (pending[i]) begin
        sel      = CHAN_W'(i);
        any_pend = 1'b1;
      end
    end
  end

  assign pop  = rd_valid && rd_ready;
  assign push = any_pend && (!fifo_full || pop);

  always_comb begin
    drain = '0;
    for (int i = 0; i < CH; i++) begin
      drain[i] = push && (sel == CHAN_W'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen     <= '0;
      pending  <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        last_seen[i] <= '0;
        pend_val[i]  <= '0;
`ifdef TRACE_TIMESTAMP_EN
        pend_ts[i]   <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (change[i]) begin
          last_seen[i] <= obs_data[i*DATA_W +: DATA_W];
          pend_val[i]  <= obs_data[i*DATA_W +: DATA_W];
`ifdef TRACE_TIMESTAMP_EN
          pend_ts[i]   <= cycle_cnt;
`endif
          seen[i]      <= 1'b1;
          // A draining entry is written out this cycle, so only an undrained one is lost.
          pending[i]   <= 1'b1;
          if (pending[i] && !drain[i]) overflow <= 1'b1;
        end else if (drain[i]) begin
          pending[i]   <= 1'b0;
        end
      end
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  assign wr_entry = {sel, pend_val[sel], pend_ts[sel]};
  assign rd_chan  = rd_entry[ENTRY_W-1 -: CHAN_W];
  assign rd_data  = rd_entry[TS_W +: DATA_W];
  assign rd_ts    = rd_entry[TS_W-1:0];
`else
  assign wr_entry = {sel, pend_val[sel]};
  assign rd_chan  = rd_entry[ENTRY_W-1 -: CHAN_W];
  assign rd_data  = rd_entry[DATA_W-1:0];
  assign rd_ts    = '0;
`endif

  assign rd_valid = !fifo_empty;

  mips_trace_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

endmodule

`default_nettype wire

// File: tb/tb_mips_trace_buffer.sv
// ----------------------------------------------------------------------------
// tb_mips_trace_buffer : directed self-checking bench for mips_trace_buffer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mips_trace_buffer;

  localparam int DATA_W = 32;
  localparam int CH     = 2;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;
  localparam int CLIM   = 25;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 arm = 1'b0;
  logic [CH-1:0]        obs_valid = '0;
  logic [CH*DATA_W-1:0] obs_data = '0;
  logic                 rd_ready = 1'b0;
  logic                 rd_valid;
  logic [0:0]           rd_chan;
  logic [DATA_W-1:0]    rd_data;
  logic [TS_W-1:0]      rd_ts;
  logic [4:0]           count;
  logic                 overflow;
  logic                 running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_trace_buffer #(
    .DATA_W(DATA_W), .CH(CH), .DEPTH(DEPTH), .TS_W(TS_W), .CYCLE_LIMIT(CLIM)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .obs_valid(obs_valid), .obs_data(obs_data),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_chan(rd_chan), .rd_data(rd_data),
    .rd_ts(rd_ts), .count(count), .overflow(overflow), .running(running)
  );

  // Expected timestamp: capture time when timestamps are built, otherwise zero.
  function automatic logic [TS_W-1:0] ets(input int v);
`ifdef TRACE_TIMESTAMP_EN
    return TS_W'(v);
`else
    return TS_W'(0);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; arm = 1'b0; obs_valid = '0; obs_data = '0; rd_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic arm_pulse();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset_and_arm();
    do_reset();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %0h want 0", rd_valid); end
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
    checks++; if ({overflow, running} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {overflow, running}); end
    checks++; if ({rd_chan, rd_data, rd_ts} !== '0) begin errors++; $display("FAIL rst_rd_fields got %0h/%0h/%0h want 0/0/0", rd_chan, rd_data, rd_ts); end
    arm_pulse();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL arm_running got %0h want 1", running); end
    obs_valid = 2'b01;
    obs_data[31:0] = 32'd5; tick();
    obs_data[31:0] = 32'd7; tick();
    checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %0h want 1", rd_valid); end
    checks++; if ({rd_chan, rd_data} !== {1'b0, 32'd5}) begin errors++; $display("FAIL t1_entry0 got ch%0d %0h want ch0 5", rd_chan, rd_data); end
    checks++; if (rd_ts !== ets(0)) begin errors++; $display("FAIL t1_ts0 got %0d want %0d", rd_ts, ets(0)); end
    rd_ready = 1'b1; tick();
    checks++; if ({rd_chan, rd_data} !== {1'b0, 32'd7}) begin errors++; $display("FAIL t1_entry1 got ch%0d %0h want ch0 7", rd_chan, rd_data); end
    checks++; if (rd_ts !== ets(1)) begin errors++; $display("FAIL t1_ts1 got %0d want %0d", rd_ts, ets(1)); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL t1_count_rw got %0d want 1", count); end
    tick(); tick(); tick();
    checks++; if ({rd_valid, count} !== 6'd0) begin errors++; $display("FAIL t1_no_repeat got valid %0h count %0d want 0 0", rd_valid, count); end
    rd_ready = 1'b0; obs_valid = '0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    arm_pulse();
    obs_valid = 2'b11;
    obs_data = {32'hB, 32'hA};
    tick();
    tick();
    checks++; if ({rd_valid, rd_chan, rd_data, count} !== {1'b1, 1'b0, 32'hA, 5'd1}) begin errors++; $display("FAIL t2_first got v%0h ch%0d %0h cnt%0d want v1 ch0 a cnt1", rd_valid, rd_chan, rd_data, count); end
    tick();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL t2_count got %0d want 2", count); end
    rd_ready = 1'b1; tick();
    checks++; if ({rd_chan, rd_data} !== {1'b1, 32'hB}) begin errors++; $display("FAIL t2_second got ch%0d %0h want ch1 b", rd_chan, rd_data); end
    checks++; if (rd_ts !== ets(0)) begin errors++; $display("FAIL t2_ts got %0d want %0d", rd_ts, ets(0)); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t2_overflow got %0h want 0", overflow); end
    tick();
    rd_ready = 1'b0; obs_valid = '0;
  endtask

  task automatic test_full_fifo();
    do_reset();
    arm_pulse();
    obs_valid = 2'b01;
    for (int k = 1; k <= 16; k++) begin
      obs_data[31:0] = k;
      tick();
    end
    tick();
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL t3_full_count got %0d want 16", count); end
    obs_data[31:0] = 32'd100; tick();
    checks++; if ({count, overflow} !== {5'd16, 1'b0}) begin errors++; $display("FAIL t3_held got cnt%0d ovf%0h want cnt16 ovf0", count, overflow); end
    checks++; if (rd_data !== 32'd1) begin errors++; $display("FAIL t3_head got %0h want 1", rd_data); end
    obs_data[31:0] = 32'd101; tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t3_overflow got %0h want 1", overflow); end
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL t3_rw_full got %0d want 16", count); end
    checks++; if ({rd_data, rd_ts} !== {32'd2, ets(1)}) begin errors++; $display("FAIL t3_next got %0h ts%0d want 2 ts%0d", rd_data, rd_ts, ets(1)); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL t3_running got %0h want 1", running); end
    obs_valid = '0;
  endtask

  task automatic test_cycle_limit();
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t4_ovf_cleared got %0h want 0", overflow); end
    arm_pulse();
    obs_valid = 2'b01;
    obs_data[31:0] = 32'd1;
    for (int k = 0; k < 24; k++) tick();
    checks++; if ({running, count} !== {1'b1, 5'd1}) begin errors++; $display("FAIL t4_pre_limit got run%0h cnt%0d want run1 cnt1", running, count); end
    obs_data[31:0] = 32'd50; tick();
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL t4_stop got %0h want 0", running); end
    tick();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL t4_drain_after_stop got %0d want 2", count); end
    obs_data[31:0] = 32'd60; tick(); tick(); tick();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL t4_frozen got %0d want 2", count); end
    rd_ready = 1'b1; tick();
    checks++; if ({rd_data, rd_ts} !== {32'd50, ets(24)}) begin errors++; $display("FAIL t4_last got %0h ts%0d want 32 ts%0d", rd_data, rd_ts, ets(24)); end
    tick(); rd_ready = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL t4_empty got %0h want 0", rd_valid); end
    arm_pulse();
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL t4_rearm got %0h want 1", running); end
    obs_data[31:0] = 32'd61; tick(); tick();
    checks++; if ({rd_valid, rd_data, rd_ts} !== {1'b1, 32'd61, ets(0)}) begin errors++; $display("FAIL t4_restart got v%0h %0h ts%0d want v1 3d ts%0d", rd_valid, rd_data, rd_ts, ets(0)); end
    obs_valid = '0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    arm_pulse();
    obs_valid = 2'b01;
    for (int k = 1; k <= 6; k++) begin
      obs_data[31:0] = 32'd10 + k;
      tick();
    end
    tick();
    checks++; if (count !== 5'd6) begin errors++; $display("FAIL t5_count6 got %0d want 6", count); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({rd_valid, count, overflow, running} !== 8'd0) begin errors++; $display("FAIL t5_async v%0h cnt%0d ovf%0h run%0h want all 0", rd_valid, count, overflow, running); end
    checks++; if ({rd_chan, rd_data, rd_ts} !== '0) begin errors++; $display("FAIL t5_async_fields got %0h/%0h/%0h want 0/0/0", rd_chan, rd_data, rd_ts); end
    tick();
    reset = 1'b0;
    obs_data[31:0] = 32'd77; tick(); tick();
    checks++; if ({running, count} !== 6'd0) begin errors++; $display("FAIL t5_idle got run%0h cnt%0d want 0 0", running, count); end
    obs_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset_and_arm();
    test_same_cycle();
    test_full_fifo();
    test_cycle_limit();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Synthesizable trace capture unit for the MIPS32 processor. It watches CH observation channels, such as the processor output word or the writeback instruction. On each value change it stores an entry of {channel, data, optional timestamp} into a circular FIFO, and a consumer drains the FIFO through a valid/ready port. A built-in cycle limit replaces the fixed simulation stop time: the unit freezes capture after a programmable number of cycles, and the buffer stays readable afterwards.

## Interface
- DATA_W, 32, width of each observed channel
- CH, 2, number of observed channels; must be ≥2
- DEPTH, 16, FIFO entries; must be a power of 2, ≥2
- TS_W, 16, width of the cycle counter and timestamp
- CYCLE_LIMIT, 25, RUN cycles before automatic stop; 0 = never stop
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- arm  in  1  pulse; IDLE/STOPPED → RUN
- obs_valid  in  CH  per-channel sample qualifier
- obs_data  in  CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- rd_ready  in  1  consumer accepts the head entry
- rd_valid  out  1  FIFO not empty
- rd_chan  out  $clog2(CH)  channel of the head entry
- rd_data  out  DATA_W  data of the head entry
- rd_ts  out  TS_W  timestamp of the head entry
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: at least one change was lost
- running  out  1  state == RUN

## Operation
- **States:**
  - IDLE (after reset): `arm` → RUN.
  - RUN: cycle counter reaches CYCLE_LIMIT−1 and CYCLE_LIMIT≠0 → STOPPED. `arm` in RUN is ignored.
  - STOPPED: `arm` → RUN.
  - On any entry to RUN: cycle counter cleared to 0. FIFO, overflow and last-seen registers are retained.
- **Cycle counter:** increments every RUN cycle and wraps modulo 2^TS_W. It holds in IDLE and STOPPED.
- **Change detect (RUN only):** channel i changes when obs_valid[i]=1 and either obs_data[i] differs from last_seen[i] or seen[i]=0.
  - On a change: last_seen[i]←data, seen[i]←1, pending[i]←1, pend_val[i]←data, pend_ts[i]←counter.
  - A change while pending[i]=1 and not drained this cycle overwrites pend_val/pend_ts and sets overflow.
- **Arbiter:** each cycle, the lowest-index pending channel is written to the FIFO if it is not full, and its pending flag clears. At most one write per cycle.
- **Full FIFO:** pending entries wait; they are not dropped. Loss happens only through the overwrite rule above.
- **Read:** rd_valid && rd_ready pops the head. The FIFO is show-ahead, so rd_* always presents the head entry.
- **Simultaneous read and write:** allowed at any occupancy, including full (the pop frees the slot the write uses). Count is unchanged.
- **Pointers:** $clog2(DEPTH) bits, wrap naturally.
- **Leaving RUN:** pending entries still drain into the FIFO after RUN exits. New changes are ignored.

## Timing
- Reset values: rd_valid=0, rd_chan=0, rd_data=0, rd_ts=0, count=0, overflow=0, running=0. State=IDLE, counter=0, pending=0, seen=0.
- Reset asserted mid-operation clears everything immediately (asynchronous); contents in flight are discarded.
- Change sampled at edge N → FIFO write at edge N+1 (if selected and not full) → rd_valid=1 after edge N+1.
- Pop at edge M → rd_valid/rd_* reflect the next entry after edge M.
- rd_ts = counter value at sample edge N.
- `running` rises after the edge that samples `arm` and falls after the edge where the counter equals CYCLE_LIMIT−1.

## Configuration
- **TRACE_TIMESTAMP_EN defined:** timestamp storage exists in the pending registers and the FIFO, and rd_ts carries capture times.
- **Not defined:** no timestamp storage is built and rd_ts is tied to 0. The cycle counter remains, because the stop logic needs it. Port lists are identical in both builds.

## Structure
- **Package `mips_trace_pkg`:** state enum (IDLE, RUN, STOPPED), and entry field-width localparam helpers (CHAN_W, PTR_W).
- **Sub-module `mips_trace_fifo`:** parametrised by entry width and DEPTH. It provides show-ahead output, full/empty, count, and simultaneous push/pop.
- Change detect, arbiter, counter and FSM live in the top module.

## Test plan
1. **Reset and arm:** reset pulse, then arm; ch0 presents 5 then 7 on consecutive cycles → two entries (ch0,5,ts0), (ch0,7,ts1) with rd_ready=1. No entry for an unchanged value.
2. **Same-cycle changes:** ch0=0xA and ch1=0xB change in the same cycle → entry ch0 written at N+1, ch1 at N+2. overflow=0.
3. **Full FIFO:** rd_ready=0, distinct values written until count=DEPTH=16.
   - A further ch0 change is held pending.
   - A second ch0 change before any pop → overflow=1.
   - A simultaneous pop+write at full leaves count=16.
4. **Cycle limit:** CYCLE_LIMIT=25 → running drops after 25 RUN cycles. Later changes produce no entries, and the buffer still drains. arm restarts with the timestamp at 0.
5. **Reset mid-run:** reset asserted with count=6 → all outputs return to their reset values immediately, and state=IDLE.
6. **Build without TRACE_TIMESTAMP_EN:** scenario 1 yields rd_ts=0 for every entry, with data and channel unchanged.
